// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one read per cycle to a 1-cycle memory,
// and delivers words through a 2-entry buffer. A word reaches decode 2 cycles after its request; the buffer plus in-flight limit keeps decode stalls lossless.
module imem_fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       WORD_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              imem_addr_err,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [ADDR_W-1:0] pc;
        logic              fault;
    } entry_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] req_pc_q;
    logic [1:0]        count_q;
    entry_t            ent0_q;
    entry_t            ent1_q;

    logic              pop;
    logic              push;
    logic              push_fault;
    logic [ADDR_W-1:0] redir_pc;
    logic [2:0]        occ;
    logic [2:0]        limit;
    entry_t            new_ent;

    assign redir_pc   = redirect_pc & ~ADDR_W'(3);
    assign pop        = inst_valid & inst_ready;
    // Responses landing after a fault or during a redirect are stale and never enter the buffer.
    assign push       = inflight_q & (state_q != FAULT) & ~redirect_valid;
    assign push_fault = push & imem_addr_err;
    assign occ        = {1'b0, count_q} + {2'b00, inflight_q};
    assign limit      = 3'(DEPTH) + {2'b00, pop};

    always_comb begin
        new_ent.data  = imem_addr_err ? '0 : imem_data;
        new_ent.pc    = req_pc_q;
        new_ent.fault = imem_addr_err;
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        pc_d      = pc_q;
        state_d   = state_q;

        if (redirect_valid) begin
            imem_req  = (state_q == RUN) || (state_q == FAULT);
            imem_addr = redir_pc;
            pc_d      = ((state_q == RUN) || (state_q == FAULT)) ? redir_pc + ADDR_W'(4) : redir_pc;
        end else begin
            imem_req = (state_q == RUN) && (occ < limit);
            if (imem_req) begin
                pc_d = pc_q + ADDR_W'(4);
            end
        end

        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A fault wins over a simultaneous stop so the error is never lost.
                if (push_fault) begin
                    state_d = FAULT;
                end else if (!fetch_en) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (redirect_valid) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            count_q    <= 2'd0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= imem_req;
            if (imem_req) begin
                req_pc_q <= imem_addr;
            end

            if (redirect_valid) begin
                count_q <= 2'd0;
            end else begin
                // Push with pop only happens at count 1: the issue limit rules out a full buffer.
                case ({push, pop})
                    2'b01: begin
                        ent0_q  <= ent1_q;
                        count_q <= count_q - 2'd1;
                    end
                    2'b10: begin
                        if (count_q == 2'd0) begin
                            ent0_q <= new_ent;
                        end else begin
                            ent1_q <= new_ent;
                        end
                        count_q <= count_q + 2'd1;
                    end
                    2'b11: begin
                        ent0_q <= new_ent;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign inst_valid = (count_q != 2'd0);
    assign inst_data  = inst_valid ? ent0_q.data : '0;
    assign inst_pc    = inst_valid ? ent0_q.pc : '0;
    assign inst_fault = inst_valid & ent0_q.fault;

endmodule
